// File: rtl/a_pulse_conditioner_if.sv
// Signal bundle between the raw-input conditioner and whatever drives/consumes it.
// The slave side is the conditioner; the master side drives din/en and observes the results.
interface a_pulse_conditioner_if #(
  parameter int GLITCH_W = 8
);
  logic                din;
  logic                en;
  logic                a;
  logic                level;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (output din, en, input a, level, busy, glitch_cnt);
  modport slave  (input din, en, output a, level, busy, glitch_cnt);
endinterface

// File: rtl/a_pulse_conditioner.sv
// Synchronises and debounces a raw input, emitting one single-cycle 'a' pulse per clean
// rising edge for the downstream step sequencer, and counts rejected glitches.
module a_pulse_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int GLITCH_W    = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  a_pulse_conditioner_if.slave   pif
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   din_s;
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   a_reg, a_next;
  logic                   level_reg, level_next;
  logic                   busy_reg, busy_next;
  logic [GLITCH_W-1:0]    glitch_reg, glitch_next;
  logic                   reject;

  assign din_s = sync_reg[SYNC_STAGES-1];

  // The synchroniser keeps running regardless of en.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg   <= '0;
      state_reg  <= LOW;
      cnt_reg    <= '0;
      a_reg      <= 1'b0;
      level_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      glitch_reg <= '0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], pif.din};
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      level_reg  <= level_next;
      busy_reg   <= busy_next;
      glitch_reg <= glitch_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!pif.en) begin
      state_next = LOW;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        LOW: begin
          if (din_s) begin
            state_next = RISE_CHK;
            cnt_next   = '0;
          end
        end
        RISE_CHK: begin
          if (!din_s)                  state_next = LOW;
          else if (cnt_reg == CNT_LAST) state_next = HIGH;
          else                          cnt_next   = cnt_reg + 1'b1;
        end
        HIGH: begin
          if (!din_s) begin
            state_next = FALL_CHK;
            cnt_next   = '0;
          end
        end
        FALL_CHK: begin
          if (din_s)                    state_next = HIGH;
          else if (cnt_reg == CNT_LAST) state_next = LOW;
          else                          cnt_next   = cnt_reg + 1'b1;
        end
        default: begin
          state_next = LOW;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // A check that falls back to where it started was a glitch; en=0 aborts are not counted.
  always_comb begin
    reject = pif.en &&
             (((state_reg == RISE_CHK) && (state_next == LOW)) ||
              ((state_reg == FALL_CHK) && (state_next == HIGH)));
    a_next      = (state_reg == RISE_CHK) && (state_next == HIGH);
    level_next  = (state_next == HIGH) || (state_next == FALL_CHK);
    busy_next   = (state_next == RISE_CHK) || (state_next == FALL_CHK);
    glitch_next = glitch_reg;
    if (reject && !(&glitch_reg))
      glitch_next = glitch_reg + 1'b1;
  end

  assign pif.a          = a_reg;
  assign pif.level      = level_reg;
  assign pif.busy       = busy_reg;
  assign pif.glitch_cnt = glitch_reg;

endmodule

// File: tb/tb_a_pulse_conditioner.sv
// Directed bench for a_pulse_conditioner: a run-length debounce model checked every cycle,
// plus hand-computed latencies and counts for the scenarios of interest.
module tb_a_pulse_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int GW   = 8;
  localparam int GMAX = (1 << GW) - 1;

  logic clk;
  logic rstn;

  a_pulse_conditioner_if #(.GLITCH_W(GW)) pif ();

  a_pulse_conditioner #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB), .GLITCH_W(GW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .pif  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: level flips once DB+1 consecutive synced samples disagree with it;
  // any shorter disagreement run that ends is one glitch.
  typedef struct {
    logic [7:0] hist;
    logic       lvl;
    int         run;
    logic       a;
    logic       busy;
    int         gl;
  } mstate_t;

  mstate_t mdl;

  function automatic mstate_t step(mstate_t m, logic d, logic e);
    mstate_t n = m;
    logic ds;
    ds     = m.hist[SYNC-1];
    n.hist = {m.hist[6:0], d};
    n.a    = 1'b0;
    if (!e) begin
      n.lvl = 1'b0;
      n.run = 0;
    end else if (ds != m.lvl) begin
      n.run = m.run + 1;
      if (n.run == DB + 1) begin
        n.a   = ds;
        n.lvl = ds;
        n.run = 0;
      end
    end else begin
      if (m.run > 0 && m.gl < GMAX) n.gl = m.gl + 1;
      n.run = 0;
    end
    n.busy = (n.run > 0);
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) mdl <= '{hist: 8'h00, lvl: 1'b0, run: 0, a: 1'b0, busy: 1'b0, gl: 0};
    else       mdl <= step(mdl, pif.din, pif.en);
  end

  always @(negedge clk) begin
    chk("a",          32'(pif.a),          32'(mdl.a));
    chk("level",      32'(pif.level),      32'(mdl.lvl));
    chk("busy",       32'(pif.busy),       32'(mdl.busy));
    chk("glitch_cnt", 32'(pif.glitch_cnt), 32'(mdl.gl));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Returns the index of the first clock edge (1 = first edge after the call) after which a=1; 0 on timeout.
  task automatic wait_a(input int limit, output int edges);
    edges = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (pif.a === 1'b1) begin
        edges = i;
        break;
      end
    end
    #1;
  endtask

  initial begin
    int e;
    int pulses;
    int seq;

    pif.din = 1'b0;
    pif.en  = 1'b1;
    rstn    = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(20);
    chk("idle_level", 32'(pif.level), 32'd0);
    chk("idle_glitch", 32'(pif.glitch_cnt), 32'd0);

    // Clean press: pulse and level 6 edges after the first sampling edge.
    pif.din = 1'b1;
    wait_a(20, e);
    chk("rise_latency", 32'(e - 1), 32'd6);
    chk("rise_level", 32'(pif.level), 32'd1);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pif.a) pulses++;
    end
    #1;
    chk("hold_pulses", 32'(pulses), 32'd0);

    pif.din = 1'b0;
    e = 0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pif.a) pulses++;
      if (pif.level === 1'b0) begin
        e = i;
        break;
      end
    end
    #1;
    chk("fall_latency", 32'(e - 1), 32'd6);
    chk("fall_pulses", 32'(pulses), 32'd0);
    tick(10);

    // Short glitches: rejected, counted, saturating.
    for (int r = 0; r < 300; r++) begin
      pif.din = 1'b1;
      tick(3);
      pif.din = 1'b0;
      tick(5);
      if (r == 0) begin
        chk("glitch_once", 32'(pif.glitch_cnt), 32'd1);
        chk("glitch_level", 32'(pif.level), 32'd0);
      end
    end
    chk("glitch_sat", 32'(pif.glitch_cnt), 32'd255);

    // Four presses drive a mod-4 sequencer back to its start.
    pulses = 0;
    seq = 0;
    for (int p = 0; p < 4; p++) begin
      pif.din = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (pif.a) begin pulses++; seq = (seq + 1) % 4; end
      end
      #1;
      pif.din = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (pif.a) begin pulses++; seq = (seq + 1) % 4; end
      end
      #1;
    end
    chk("four_pulses", 32'(pulses), 32'd4);
    chk("seq_home", 32'(seq), 32'd0);

    // en dropped so it is sampled on the edge where the pulse would fire.
    pif.din = 1'b1;
    tick(6);
    pif.en = 1'b0;
    tick(1);
    chk("endrop_a", 32'(pif.a), 32'd0);
    chk("endrop_level", 32'(pif.level), 32'd0);
    chk("endrop_busy", 32'(pif.busy), 32'd0);
    tick(3);
    pif.en = 1'b1;
    wait_a(20, e);
    chk("enrise_edges", 32'(e), 32'(DB + 1));
    pif.din = 1'b0;
    tick(15);

    // Reset in the middle of a rise check, din held high across release.
    pif.din = 1'b1;
    tick(4);
    chk("midchk_busy", 32'(pif.busy), 32'd1);
    rstn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pif.a) pulses++;
    end
    #1;
    chk("reset_pulses", 32'(pulses), 32'd0);
    chk("reset_glitch", 32'(pif.glitch_cnt), 32'd0);
    rstn = 1'b1;
    wait_a(20, e);
    chk("reset_release_edges", 32'(e), 32'(SYNC + DB + 1));
    pif.din = 1'b0;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
